cgra_ctx_mem_obi_responder: RTL and testbench

OBI slave endpoint behind the external crossbar's CGRA context-memory slave port (index CGRA_IDX). It accepts bus requests routed to the CGRA window and converts them into single-port SRAM accesses to the context memory, which has a fixed read latency. Responses return in order with the same latency, and error responses are generated for illegal accesses. Decoded window bounds come from heepsilon_pkg, so this block answers requests that the crossbar address rules route to it.

---
 rtl/heepsilon_pkg.sv | 33 +++
 rtl/cgra_rsp_pipe.sv | 40 ++++
 rtl/cgra_ctx_mem_obi_responder.sv | 86 ++++++++
 tb/tb_cgra_ctx_mem_obi_responder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/heepsilon_pkg.sv
// Shared address map and CGRA context-memory definitions for the HEEPsilon system.
package heepsilon_pkg;

   localparam logic [31:0] CGRA_START_ADDRESS = 32'hF000_0000;
   localparam logic [31:0] CGRA_SIZE          = 32'h0001_0000;

   localparam int unsigned CGRA_CTX_MEM_AW  = 10;
   localparam int unsigned CGRA_CTX_MEM_LAT = 1;

   // One in-flight response slot of the context-memory responder.
   typedef struct packed {
      logic valid;
      logic err;
      logic we;
   } cgra_rsp_tag_t;

   // True when a byte address cannot be served by the context memory: below the
   // window, past the window, not word aligned, or past the last memory word.
   function automatic logic cgra_addr_illegal(
      input logic [31:0] addr,
      input logic [31:0] base,
      input logic [31:0] size,
      input int unsigned aw
   );
      logic [31:0] off;
      logic [31:0] word_lim;
      off      = addr - base;
      word_lim = 32'd1 << aw;
      return (addr < base) | (off >= size) | (addr[1:0] != 2'b00) |
             ({2'b00, off[31:2]} >= word_lim);
   endfunction

endpackage

// File: rtl/cgra_rsp_pipe.sv
// Fixed-depth shift register of response tags; one slot per memory latency cycle.
module cgra_rsp_pipe
   import heepsilon_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  cgra_rsp_tag_t load_tag,
   output cgra_rsp_tag_t last_tag,
   output logic          any_valid
);

   cgra_rsp_tag_t stage_r [DEPTH];

   // Shift tags one slot per cycle; reset discards every in-flight response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            stage_r[i] <= '0;
         end
      end else begin
         stage_r[0] <= load_tag;
         for (int i = 1; i < int'(DEPTH); i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   // Flag whether any slot still carries a response.
   always_comb begin
      any_valid = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         any_valid = any_valid | stage_r[i].valid;
      end
   end

   assign last_tag = stage_r[DEPTH-1];

endmodule

// File: rtl/cgra_ctx_mem_obi_responder.sv
// OBI slave that turns crossbar requests into fixed-latency context-memory accesses,
// answering out-of-range or misaligned requests with an in-order error response.
module cgra_ctx_mem_obi_responder
   import heepsilon_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = CGRA_START_ADDRESS,
   parameter logic [31:0] WIN_SIZE  = CGRA_SIZE,
   parameter int unsigned MEM_AW    = CGRA_CTX_MEM_AW,
   parameter int unsigned MEM_LAT   = CGRA_CTX_MEM_LAT
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_i,
   output logic              gnt_o,
   input  logic [31:0]       addr_i,
   input  logic              we_i,
   input  logic [3:0]        be_i,
   input  logic [31:0]       wdata_i,
   output logic              rvalid_o,
   output logic [31:0]       rdata_o,
   output logic              err_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [MEM_AW-1:0] mem_addr_o,
   output logic [3:0]        mem_be_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_ready_i,
   input  logic [31:0]       mem_rdata_i,
   output logic              busy_o
);

   logic [31:0]   off_s;
   logic          illegal_s;
   logic          accept_s;
   cgra_rsp_tag_t load_tag_s;
   cgra_rsp_tag_t last_tag_s;
   logic          any_valid_s;

   // Window decode; illegal requests never need the memory so they never stall.
   always_comb begin
      off_s     = addr_i - BASE_ADDR;
      illegal_s = cgra_addr_illegal(addr_i, BASE_ADDR, WIN_SIZE, MEM_AW);
   end

   assign gnt_o    = req_i & (illegal_s | mem_ready_i);
   assign accept_s = req_i & gnt_o;

   assign mem_req_o   = accept_s & ~illegal_s;
   assign mem_we_o    = we_i;
   assign mem_addr_o  = off_s[MEM_AW+1:2];
   assign mem_be_o    = be_i;
   assign mem_wdata_o = wdata_i;

   // Tag every accepted transaction so its response emerges MEM_LAT cycles later.
   always_comb begin
      if (accept_s) begin
         load_tag_s = '{valid: 1'b1, err: illegal_s, we: we_i};
      end else begin
         load_tag_s = '0;
      end
   end

   cgra_rsp_pipe #(
      .DEPTH (MEM_LAT)
   ) u_rsp_pipe (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .load_tag  (load_tag_s),
      .last_tag  (last_tag_s),
      .any_valid (any_valid_s)
   );

   assign rvalid_o = last_tag_s.valid;
   assign err_o    = last_tag_s.valid & last_tag_s.err;
   assign busy_o   = any_valid_s;

   // Only a successful read returns memory data; writes and errors return zero.
   always_comb begin
      if (last_tag_s.valid & ~last_tag_s.err & ~last_tag_s.we) begin
         rdata_o = mem_rdata_i;
      end else begin
         rdata_o = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_cgra_ctx_mem_obi_responder.sv
// Self-checking bench: two responders (latency 1 and 3) share one request stream,
// each backed by a behavioural SRAM; a scoreboard predicts every response.
module tb_cgra_ctx_mem_obi_responder;

   localparam logic [31:0] BASE = 32'hF000_0000;
   localparam logic [31:0] WIN  = 32'h0001_0000;
   localparam int          WORDS = 1024;

   logic        clk, rst_n, req, we, ready, preload;
   logic [31:0] addr, wdata;
   logic [3:0]  be;

   logic        g1, rv1, er1, mreq1, mwe1, bz1;
   logic [31:0] rd1, mwd1, mrd1;
   logic [9:0]  maddr1;
   logic [3:0]  mbe1;
   logic        g3, rv3, er3, mreq3, mwe3, bz3;
   logic [31:0] rdo3, mwd3;
   logic [9:0]  maddr3;
   logic [3:0]  mbe3;

   logic [31:0] mem1 [0:WORDS-1];
   logic [31:0] mem3 [0:WORDS-1];
   logic [31:0] rdp3 [0:2];
   logic [31:0] shadow [0:WORDS-1];

   typedef struct {
      int          due;
      bit          err;
      bit          rd;
      logic [31:0] data;
   } exp_t;
   exp_t q1[$];
   exp_t q3[$];

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        ready;
      logic        exp_gnt;
      logic        exp_mreq;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   cgra_ctx_mem_obi_responder #(.MEM_LAT(1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(g1), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .rvalid_o(rv1), .rdata_o(rd1), .err_o(er1),
      .mem_req_o(mreq1), .mem_we_o(mwe1), .mem_addr_o(maddr1), .mem_be_o(mbe1),
      .mem_wdata_o(mwd1), .mem_ready_i(ready), .mem_rdata_i(mrd1), .busy_o(bz1));

   cgra_ctx_mem_obi_responder #(.MEM_LAT(3)) u_dut3 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(g3), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .rvalid_o(rv3), .rdata_o(rdo3), .err_o(er3),
      .mem_req_o(mreq3), .mem_we_o(mwe3), .mem_addr_o(maddr3), .mem_be_o(mbe3),
      .mem_wdata_o(mwd3), .mem_ready_i(ready), .mem_rdata_i(rdp3[2]), .busy_o(bz3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Latency-1 SRAM model.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < WORDS; i++) mem1[i] <= 32'(i);
      end else if (mreq1 && ready && mwe1) begin
         for (int b = 0; b < 4; b++)
            if (mbe1[b]) mem1[maddr1][8*b +: 8] <= mwd1[8*b +: 8];
      end
      mrd1 <= (mreq1 && ready && !mwe1) ? mem1[maddr1] : 32'hA5A5_5A5A;
   end

   // Latency-3 SRAM model.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < WORDS; i++) mem3[i] <= 32'(i);
      end else if (mreq3 && ready && mwe3) begin
         for (int b = 0; b < 4; b++)
            if (mbe3[b]) mem3[maddr3][8*b +: 8] <= mwd3[8*b +: 8];
      end
      rdp3[0] <= (mreq3 && ready && !mwe3) ? mem3[maddr3] : 32'h5A5A_A5A5;
      rdp3[1] <= rdp3[0];
      rdp3[2] <= rdp3[1];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic bit legal(input logic [31:0] a);
      longint unsigned off;
      if (a < BASE) return 1'b0;
      off = longint'(a) - longint'(BASE);
      return (off < longint'(WIN)) && (a % 4 == 0) && (off / 4 < WORDS);
   endfunction

   task automatic check_rsp(input string tag, input int lat, input logic rv, input logic er,
                            input logic [31:0] rd, input logic bz);
      exp_t e;
      bit   nonempty, due;
      if (lat == 1) begin
         nonempty = q1.size() != 0;
         due = nonempty && q1[0].due == cyc;
         if (due) e = q1.pop_front();
      end else begin
         nonempty = q3.size() != 0;
         due = nonempty && q3[0].due == cyc;
         if (due) e = q3.pop_front();
      end
      chk({tag, "_busy"}, 32'(bz), 32'(nonempty));
      chk({tag, "_rvalid"}, 32'(rv), 32'(due));
      if (due) begin
         chk({tag, "_err"}, 32'(er), 32'(e.err));
         chk({tag, "_rdata"}, rd, (e.err || !e.rd) ? 32'h0 : e.data);
      end else begin
         chk({tag, "_err_idle"}, 32'(er), 32'h0);
         chk({tag, "_rdata_idle"}, rd, 32'h0);
      end
   endtask

   // One bus cycle with the inputs already driven: check, record, advance.
   task automatic step();
      bit   lg, gnt_exp;
      int   w;
      exp_t e;
      #1;
      lg      = legal(addr);
      gnt_exp = req && (!lg || ready);
      chk("gnt1", 32'(g1), 32'(gnt_exp));
      chk("gnt3", 32'(g3), 32'(gnt_exp));
      chk("mreq1", 32'(mreq1), 32'(gnt_exp && lg));
      chk("mreq3", 32'(mreq3), 32'(gnt_exp && lg));
      if (gnt_exp && lg) begin
         chk("maddr1", 32'(maddr1), (addr - BASE) / 4);
         chk("maddr3", 32'(maddr3), (addr - BASE) / 4);
         chk("mpass1", {mwe1, mbe1, mwd1[26:0]}, {we, be, wdata[26:0]});
      end
      check_rsp("L1", 1, rv1, er1, rd1, bz1);
      check_rsp("L3", 3, rv3, er3, rdo3, bz3);
      if (gnt_exp) begin
         w      = lg ? int'((addr - BASE) / 4) : 0;
         e.err  = !lg;
         e.rd   = !we;
         e.data = lg ? shadow[w] : 32'h0;
         e.due  = cyc + 1;
         q1.push_back(e);
         e.due  = cyc + 3;
         q3.push_back(e);
         if (lg && we)
            for (int b = 0; b < 4; b++)
               if (be[b]) shadow[w][8*b +: 8] = wdata[8*b +: 8];
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic drive(input logic r, input logic [31:0] a, input logic w,
                        input logic [3:0] b, input logic [31:0] d, input logic rdy);
      req = r; addr = a; we = w; be = b; wdata = d; ready = rdy;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
      for (int i = 0; i < n; i++) step();
   endtask

   vec_t vecs[12];

   initial begin
      bit pend;
      for (int i = 0; i < WORDS; i++) shadow[i] = 32'(i);
      rst_n = 1'b0; preload = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
      repeat (3) @(negedge clk);
      preload = 1'b0;
      // Reset state.
      chk("rst_rvalid1", 32'(rv1), 32'h0);
      chk("rst_err1", 32'(er1), 32'h0);
      chk("rst_rdata1", rd1, 32'h0);
      chk("rst_busy1", 32'(bz1), 32'h0);
      chk("rst_rvalid3", 32'(rv3), 32'h0);
      chk("rst_busy3", 32'(bz3), 32'h0);
      rst_n = 1'b1;
      idle(2);

      // Streaming: eight back-to-back reads of words 0..7.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, BASE + 32'(i * 4), 1'b0, 4'hF, 32'h0, 1'b1);
         step();
      end
      idle(4);

      // Write then read back the same word.
      drive(1'b1, 32'hF000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1);
      #1 chk("t1_mem_addr", 32'(maddr1), 32'd4);
      step();
      drive(1'b1, 32'hF000_0010, 1'b0, 4'hF, 32'h0, 1'b1);
      step();
      #1 chk("t1_rdata", rd1, 32'hDEAD_BEEF);
      chk("t1_err", 32'(er1), 32'h0);
      idle(3);

      // Table of single-cycle requests, applied back to back.
      vecs[0]  = '{32'hF010_0000, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b0};
      vecs[1]  = '{32'hF000_0002, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b0};
      vecs[2]  = '{32'hEFFF_FFFC, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b0};
      vecs[3]  = '{32'hF000_1000, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b0};
      vecs[4]  = '{32'hF000_0FFC, 1'b1, 4'hF, 32'h1234_5678, 1'b1, 1'b1, 1'b1};
      vecs[5]  = '{32'hF000_0FFC, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1};
      vecs[6]  = '{32'hF000_0000, 1'b0, 4'hF, 32'h0,         1'b0, 1'b0, 1'b0};
      vecs[7]  = '{32'hF000_0006, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 1'b0};
      vecs[8]  = '{32'hF000_FFFC, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b0};
      vecs[9]  = '{32'hF000_0008, 1'b1, 4'h3, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b1};
      vecs[10] = '{32'h0000_0000, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b0};
      vecs[11] = '{32'hF000_0008, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata, vecs[i].ready);
         #1;
         chk($sformatf("vec%0d_gnt", i), 32'(g1), 32'(vecs[i].exp_gnt));
         chk($sformatf("vec%0d_mreq", i), 32'(mreq1), 32'(vecs[i].exp_mreq));
         step();
      end
      idle(4);

      // Backpressure: legal request held while memory is not ready.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'hF000_0020, 1'b0, 4'hF, 32'h0, 1'b0);
         #1 chk("bp_gnt_low", 32'(g1), 32'h0);
         step();
      end
      drive(1'b1, 32'hF000_0020, 1'b0, 4'hF, 32'h0, 1'b1);
      step();
      idle(1);
      #1 chk("bp_rsp_gone", 32'(rv1), 32'h0);
      idle(3);

      // Randomized traffic; a stalled legal request is held until granted.
      pend = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!pend) begin
            logic [31:0] a;
            case ($urandom_range(0, 5))
               0, 1, 2: a = BASE + (32'($urandom_range(0, 31)) << 2);
               3:       a = BASE + 32'h1000 + (32'($urandom_range(0, 255)) << 2);
               4:       a = BASE + 32'($urandom_range(0, 127));
               default: a = $urandom();
            endcase
            drive($urandom_range(0, 9) < 7, a, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), $urandom(), $urandom_range(0, 3) != 0);
         end else begin
            ready = $urandom_range(0, 3) != 0;
         end
         pend = req && legal(addr) && !ready;
         step();
      end
      idle(4);

      // Reset in the middle of two in-flight latency-3 reads.
      drive(1'b1, BASE + 32'h4, 1'b0, 4'hF, 32'h0, 1'b1);
      step();
      drive(1'b1, BASE + 32'h8, 1'b0, 4'hF, 32'h0, 1'b1);
      step();
      idle(1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy3", 32'(bz3), 32'h0);
      chk("midrst_rvalid3", 32'(rv3), 32'h0);
      chk("midrst_busy1", 32'(bz1), 32'h0);
      q1.delete();
      q3.delete();
      @(negedge clk);
      rst_n = 1'b1;
      idle(6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
